// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: interlock and sequencing controller beside the OF/EX latches.
// Detects load-use hazards, flushes on taken branches and holds EX for the full
// occupancy of multi-cycle mul/div/mod operations.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        of_valid,
    input  logic [3:0]  of_rs1,
    input  logic [3:0]  of_rs2,
    input  logic        of_uses_rs1,
    input  logic        of_uses_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_opcode,
    input  logic        ex_isld,
    input  logic [3:0]  ex_rd,
    input  logic        ex_branch_taken,
    output logic        stall_if,
    output logic        stall_of,
    output logic        bubble_ex,
    output logic        flush_if_of,
    output logic        ex_hold,
    output logic        mdu_busy,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        mdu_done
);

    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;

    // The first occupancy cycle is spent in IDLE, the last one at cnt==0,
    // so the counter is loaded with N-2.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic w_is_mul;
    logic w_is_div;
    logic w_md_start;
    logic w_lu;
    logic w_stall_if;
    logic w_stall_of;
    logic w_bubble_ex;
    logic w_flush;
    logic w_ex_hold;
    logic w_mdu_done;

    assign w_is_mul   = (ex_opcode == OP_MUL);
    assign w_is_div   = (ex_opcode == OP_DIV) || (ex_opcode == OP_MOD);
    assign w_md_start = (r_state == ST_IDLE) && ex_valid && (w_is_mul || w_is_div);
    assign w_lu       = ex_valid && ex_isld && of_valid &&
                        ((of_uses_rs1 && (of_rs1 == ex_rd)) ||
                         (of_uses_rs2 && (of_rs2 == ex_rd)));

    // State and occupancy counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and hazard output decode; branch flush outranks load-use
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall_if   = 1'b0;
        w_stall_of   = 1'b0;
        w_bubble_ex  = 1'b0;
        w_flush      = 1'b0;
        w_ex_hold    = 1'b0;
        w_mdu_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_md_start) begin
                    w_ex_hold    = 1'b1;
                    w_stall_if   = 1'b1;
                    w_stall_of   = 1'b1;
                    w_cnt_next   = w_is_mul ? MUL_LOAD : DIV_LOAD;
                    w_state_next = ST_BUSY;
                end else if (ex_valid && ex_branch_taken) begin
                    w_flush = 1'b1;
                end else if (w_lu) begin
                    w_stall_if  = 1'b1;
                    w_stall_of  = 1'b1;
                    w_bubble_ex = 1'b1;
                end
            end
            ST_BUSY: begin
                if (r_cnt != '0) begin
                    w_ex_hold  = 1'b1;
                    w_stall_if = 1'b1;
                    w_stall_of = 1'b1;
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else begin
                    w_mdu_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        // Outputs are forced quiet for as long as reset is held
        if (!rst_n) begin
            w_stall_if  = 1'b0;
            w_stall_of  = 1'b0;
            w_bubble_ex = 1'b0;
            w_flush     = 1'b0;
            w_ex_hold   = 1'b0;
            w_mdu_done  = 1'b0;
        end
    end

    assign stall_if    = w_stall_if;
    assign stall_of    = w_stall_of;
    assign bubble_ex   = w_bubble_ex;
    assign flush_if_of = w_flush;
    assign ex_hold     = w_ex_hold;
    assign mdu_done    = w_mdu_done;
    assign mdu_busy    = rst_n && (r_state == ST_BUSY);

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Saturating counts of stall and flush cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_stall_if && (r_perf_stall_cnt != 32'hFFFF_FFFF))
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            if (w_flush && (r_perf_flush_cnt != 32'hFFFF_FFFF))
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MUL_LAT=3, DIV_LAT=8).
// Expected output vectors are queued as each cycle is driven and compared
// against the observed vectors sampled 1 time unit after the falling edge.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        of_valid;
    logic [3:0]  of_rs1;
    logic [3:0]  of_rs2;
    logic        of_uses_rs1;
    logic        of_uses_rs2;
    logic        ex_valid;
    logic [4:0]  ex_opcode;
    logic        ex_isld;
    logic [3:0]  ex_rd;
    logic        ex_branch_taken;
    logic        stall_if;
    logic        stall_of;
    logic        bubble_ex;
    logic        flush_if_of;
    logic        ex_hold;
    logic        mdu_busy;
    logic        mdu_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .MUL_LAT(3),
        .DIV_LAT(8),
        .CNT_W  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .of_valid       (of_valid),
        .of_rs1         (of_rs1),
        .of_rs2         (of_rs2),
        .of_uses_rs1    (of_uses_rs1),
        .of_uses_rs2    (of_uses_rs2),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_isld        (ex_isld),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .stall_if       (stall_if),
        .stall_of       (stall_of),
        .bubble_ex      (bubble_ex),
        .flush_if_of    (flush_if_of),
        .ex_hold        (ex_hold),
        .mdu_busy       (mdu_busy),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .mdu_done       (mdu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector order: {stall_if, stall_of, bubble_ex, flush_if_of, ex_hold, mdu_busy, mdu_done}
    logic [6:0] out_vec;
    assign out_vec = {stall_if, stall_of, bubble_ex, flush_if_of, ex_hold, mdu_busy, mdu_done};

    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_LU    = 7'b1110000;
    localparam logic [6:0] E_FL    = 7'b0001000;
    localparam logic [6:0] E_START = 7'b1100100;
    localparam logic [6:0] E_BUSY  = 7'b1100110;
    localparam logic [6:0] E_DONE  = 7'b0000011;

    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;
    localparam logic [4:0] OP_LD  = 5'b01110;
    localparam logic [4:0] OP_ADD = 5'b00000;

    logic [6:0] exp_q[$];
    logic [6:0] obs_q[$];
    int errors = 0;
    int checks = 0;

    // Drive one cycle of stimulus, queue its expectation and record the DUT response
    task automatic tick(input logic rst, input logic ev, input logic [4:0] op,
                        input logic ld, input logic [3:0] rd, input logic br,
                        input logic ov, input logic [3:0] r1, input logic [3:0] r2,
                        input logic u1, input logic u2, input logic [6:0] exp_v);
        @(negedge clk);
        rst_n           = rst;
        ex_valid        = ev;
        ex_opcode       = op;
        ex_isld         = ld;
        ex_rd           = rd;
        ex_branch_taken = br;
        of_valid        = ov;
        of_rs1          = r1;
        of_rs2          = r2;
        of_uses_rs1     = u1;
        of_uses_rs2     = u2;
        exp_q.push_back(exp_v);
        #1;
        obs_q.push_back(out_vec);
    endtask

    task automatic nop(input logic [6:0] exp_v);
        tick(1'b1, 1'b0, OP_ADD, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, exp_v);
    endtask

    // EX holds a non-load instruction; OF reads r1/r2 which never match rd=0
    task automatic exop(input logic [4:0] op, input logic br, input logic [6:0] exp_v);
        tick(1'b1, 1'b1, op, 1'b0, 4'd0, br, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1, exp_v);
    endtask

    task automatic test_reset;
        int idx = 0;
        logic [6:0] e, o;
        tick(1'b0, 1'b1, OP_MUL, 1'b0, 4'd3, 1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 1'b1, E_NONE);
        tick(1'b0, 1'b1, OP_LD,  1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 4'd3, 1'b1, 1'b1, E_NONE);
        nop(E_NONE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_load_use;
        int idx = 0;
        logic [6:0] e, o;
        // ld r3 in EX, add r1,r3,r2 in OF -> one-cycle stall and bubble
        tick(1'b1, 1'b1, OP_LD, 1'b1, 4'd3, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, E_LU);
        // EX now holds the bubble -> hazard clears
        tick(1'b1, 1'b0, OP_ADD, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, E_NONE);
        // Match through rs1 only
        tick(1'b1, 1'b1, OP_LD, 1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0, E_LU);
        nop(E_NONE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_no_use;
        int idx = 0;
        logic [6:0] e, o;
        tick(1'b1, 1'b1, OP_LD,  1'b1, 4'd3, 1'b0, 1'b1, 4'd4, 4'd5, 1'b1, 1'b1, E_NONE);
        tick(1'b1, 1'b1, OP_LD,  1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 4'd5, 1'b0, 1'b1, E_NONE);
        tick(1'b1, 1'b1, OP_LD,  1'b1, 4'd3, 1'b0, 1'b1, 4'd4, 4'd3, 1'b1, 1'b0, E_NONE);
        tick(1'b1, 1'b0, OP_LD,  1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 4'd3, 1'b1, 1'b1, E_NONE);
        tick(1'b1, 1'b1, OP_LD,  1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 4'd3, 1'b1, 1'b1, E_NONE);
        tick(1'b1, 1'b1, OP_ADD, 1'b0, 4'd3, 1'b0, 1'b1, 4'd3, 4'd3, 1'b1, 1'b1, E_NONE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL no_use[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_mul;
        int idx = 0;
        logic [6:0] e, o;
        exop(OP_MUL, 1'b0, E_START);
        exop(OP_MUL, 1'b1, E_BUSY);   // branch ignored while busy
        exop(OP_MUL, 1'b0, E_DONE);
        nop(E_NONE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mul[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_mod;
        int idx = 0;
        logic [6:0] e, o;
        exop(OP_MOD, 1'b0, E_START);
        for (int i = 0; i < 6; i++) exop(OP_MOD, 1'(i % 2), E_BUSY);
        exop(OP_MOD, 1'b1, E_DONE);
        nop(E_NONE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mod[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_branch_priority;
        int idx = 0;
        logic [6:0] e, o;
        // Load-use plus taken branch -> flush only
        tick(1'b1, 1'b1, OP_LD, 1'b1, 4'd3, 1'b1, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, E_FL);
        exop(OP_ADD, 1'b1, E_FL);
        tick(1'b1, 1'b0, OP_ADD, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1, E_NONE);
        nop(E_NONE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_back_to_back;
        int idx = 0;
        logic [6:0] e, o;
        exop(OP_MUL, 1'b0, E_START);
        exop(OP_MUL, 1'b0, E_BUSY);
        exop(OP_MUL, 1'b0, E_DONE);
        exop(OP_DIV, 1'b0, E_START);
        for (int i = 0; i < 6; i++) exop(OP_DIV, 1'b0, E_BUSY);
        exop(OP_DIV, 1'b0, E_DONE);
        nop(E_NONE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid_op;
        int idx = 0;
        logic [6:0] e, o;
        exop(OP_MOD, 1'b0, E_START);   // cnt <= 6
        exop(OP_MOD, 1'b0, E_BUSY);    // cnt 6
        exop(OP_MOD, 1'b0, E_BUSY);    // cnt 5
        tick(1'b0, 1'b1, OP_MOD, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1, E_NONE); // cnt 4
        nop(E_NONE);
        nop(E_NONE);
        exop(OP_MUL, 1'b0, E_START);
        exop(OP_MUL, 1'b0, E_BUSY);
        exop(OP_MUL, 1'b0, E_DONE);
        nop(E_NONE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_op[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf;
        int idx = 0;
        logic [6:0] e, o;
        tick(1'b0, 1'b0, OP_ADD, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, E_NONE);
        tick(1'b1, 1'b1, OP_LD, 1'b1, 4'd3, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, E_LU);
        nop(E_NONE);
        exop(OP_MUL, 1'b0, E_START);
        exop(OP_MUL, 1'b0, E_BUSY);
        exop(OP_MUL, 1'b0, E_DONE);
        exop(OP_ADD, 1'b1, E_FL);
        exop(OP_ADD, 1'b1, E_FL);
        nop(E_NONE);
        checks++;
        if (perf_stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt);
        end
        checks++;
        if (perf_flush_cnt !== 32'd2) begin
            errors++;
            $display("FAIL perf_flush: got %0d expected 2", perf_flush_cnt);
        end
        force dut.r_perf_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_perf_stall_cnt;
        tick(1'b1, 1'b1, OP_LD, 1'b1, 4'd3, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, E_LU);
        tick(1'b1, 1'b1, OP_LD, 1'b1, 4'd3, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1, 1'b1, E_LU);
        nop(E_NONE);
        checks++;
        if (perf_stall_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL perf_sat: got %h expected ffffffff", perf_stall_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL perf_seq[%0d]: got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask
`endif

    initial begin
        rst_n           = 1'b0;
        of_valid        = 1'b0;
        of_rs1          = 4'd0;
        of_rs2          = 4'd0;
        of_uses_rs1     = 1'b0;
        of_uses_rs2     = 1'b0;
        ex_valid        = 1'b0;
        ex_opcode       = 5'd0;
        ex_isld         = 1'b0;
        ex_rd           = 4'd0;
        ex_branch_taken = 1'b0;
        test_reset();
        test_load_use();
        test_no_use();
        test_mul();
        test_mod();
        test_branch_priority();
        test_back_to_back();
        test_reset_mid_op();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline interlock and sequencing controller for the 5-stage 32-bit RISC core, placed beside the OF/EX pipeline latches.
- Detects load-use hazards between the OF and EX stages and holds EX while a multi-cycle mul/div/mod executes.
- Flushes IF/OF on a taken branch and drives the stall, bubble and hold enables of the pipeline registers.
- Consumes the decoded isld and branch-outcome signals plus raw 5-bit opcodes.

Parameters:
- MUL_LAT, 3, total EX occupancy in cycles for opcode 5'b00010 (mul); legal range 2..2^CNT_W+1.
- DIV_LAT, 8, total EX occupancy in cycles for opcodes 5'b00011 (div) and 5'b00100 (mod); legal range 2..2^CNT_W+1.
- CNT_W, 4, width of the occupancy down-counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- of_valid  in  1  OF stage holds a valid instruction.
- of_rs1  in  4  OF source register 1.
- of_rs2  in  4  OF source register 2.
- of_uses_rs1  in  1  OF instruction reads rs1.
- of_uses_rs2  in  1  OF instruction reads rs2.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_opcode  in  5  EX instruction opcode.
- ex_isld  in  1  EX instruction is a load (opcode 5'b01110).
- ex_rd  in  4  EX destination register.
- ex_branch_taken  in  1  EX resolved a taken beq/bgt/b/call/ret.
- stall_if  out  1  hold PC and the IF/OF latch.
- stall_of  out  1  hold the OF/EX source operands.
- bubble_ex  out  1  load a nop into the OF/EX latch.
- flush_if_of  out  1  invalidate the IF/OF and OF/EX contents.
- ex_hold  out  1  hold the EX/MA latch and EX operands.
- mdu_busy  out  1  state is BUSY.
- mdu_done  out  1  one-cycle pulse on the final occupancy cycle of a multi-cycle op.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, cnt=0. All outputs are 0 while rst_n=0. Reset mid-BUSY aborts the op; no mdu_done pulse.
- States: IDLE and BUSY.
- md_start = (state==IDLE) & ex_valid & (ex_opcode is 00010, 00011 or 00100). N = MUL_LAT for mul, DIV_LAT for div/mod.
- IDLE with md_start:
  - ex_hold=1, stall_if=1, stall_of=1, bubble_ex=0.
  - cnt<=N-2; state<=BUSY.
- BUSY with cnt!=0: ex_hold=1, stall_if=1, stall_of=1; cnt<=cnt-1.
- BUSY with cnt==0:
  - ex_hold=0, mdu_done=1, stall_if=0, stall_of=0; state<=IDLE.
  - The op occupies EX for exactly N cycles.
- In BUSY, ex_branch_taken and load-use detection are ignored.
- Load-use, combinational, evaluated only in IDLE without md_start:
  - lu = ex_valid & ex_isld & of_valid & ((of_uses_rs1 & of_rs1==ex_rd) | (of_uses_rs2 & of_rs2==ex_rd)).
  - lu=1 gives stall_if=stall_of=bubble_ex=1 for that cycle only. The next cycle EX holds the bubble, so lu clears.
- Taken branch, evaluated in IDLE without md_start:
  - ex_branch_taken=1 gives flush_if_of=1 for one cycle.
  - It overrides lu: stall_if=stall_of=bubble_ex=0 that cycle.
- ex_valid=0 clears all hazard outputs.
- No registered output latency. Every output except mdu_busy is combinational from the inputs and state.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds two output ports.
  - perf_stall_cnt out 32: counts cycles with stall_if=1.
  - perf_flush_cnt out 32: counts cycles with flush_if_of=1.
  - Both are saturating at 32'hFFFFFFFF, cleared by reset, and update on the clock edge.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Load-use: EX ld r3, OF add r1,r3,r2 (rs2=3, uses_rs2=1) -> stall_if=stall_of=bubble_ex=1 for exactly 1 cycle, then 0.
- No-use load: EX ld r3, OF reads r4/r5 -> all hazard outputs 0. Separately, with of_uses_rs1=0 and rs1=3 -> no stall.
- MUL_LAT=3: present mul in EX at cycle t -> ex_hold=1 at t and t+1, mdu_done=1 and ex_hold=0 at t+2, mdu_busy=1 at t+1 and t+2 only. Repeat with DIV_LAT=8 for mod -> hold for 7 cycles.
- Load-use and ex_branch_taken in the same cycle -> flush_if_of=1, bubble_ex=0, stall_if=0.
- Reset mid-op: assert rst_n=0 during BUSY cnt=4 -> next cycle state IDLE, all outputs 0, no mdu_done. A following mul restarts the full latency.
- HAZARD_PERF_EN: run 1 load-use, 1 mul (MUL_LAT=3), 2 taken branches -> perf_stall_cnt=3, perf_flush_cnt=2. Preload the counter near saturation via forced state -> holds 32'hFFFFFFFF.
